// File: rtl/systolic_mv_array.sv
// Pipelined fixed-point matrix-vector engine y = W*x with per-row weight loading.
// Input register, COLS registered MAC stages, then a shift/saturate output register.
module systolic_mv_array #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned FRAC_BIT = 10,
  parameter int unsigned ROWS     = 6,
  parameter int unsigned COLS     = 6,
  localparam int unsigned RW      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    w_we,
  input  logic [RW-1:0]           w_row,
  input  logic [COLS*WIDTH-1:0]   w_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [COLS*WIDTH-1:0]   in_vec,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ROWS*WIDTH-1:0]   out_vec,
  output logic                    busy,
  output logic                    w_err
);

  localparam int unsigned AW = 2 * WIDTH + $clog2(COLS) + 1;
  localparam int unsigned PW = 2 * WIDTH;

  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic signed [WIDTH-1:0] w_q   [ROWS][COLS];
  // x_q[0] is the input register; x_q[m] is the x copy held by MAC stage m.
  logic [COLS*WIDTH-1:0]   x_q   [COLS];
  logic signed [AW-1:0]    acc_q [COLS][ROWS];
  logic signed [AW-1:0]    acc_d [COLS][ROWS];
  logic [COLS:0]           v_q;
  logic                    out_valid_q;
  logic [ROWS*WIDTH-1:0]   out_vec_q;
  logic [ROWS*WIDTH-1:0]   sat_vec;
  logic                    w_err_q;

  logic stall;
  logic accept;
  logic row_ok;

  assign stall     = out_valid_q && !out_ready;
  assign in_ready  = rst_n && !stall && !w_we && !clr;
  assign accept    = in_valid && in_ready;
  assign busy      = (|v_q) || out_valid_q;
  assign row_ok    = 32'(w_row) < ROWS;
  assign out_valid = out_valid_q;
  assign out_vec   = out_vec_q;
  assign w_err     = w_err_q;

  for (genvar m = 0; m < COLS; m++) begin : g_stage
    for (genvar i = 0; i < ROWS; i++) begin : g_row
      logic signed [PW-1:0] prod;
      logic signed [AW-1:0] prod_ext;
      assign prod     = w_q[i][m] * $signed(x_q[m][m*WIDTH +: WIDTH]);
      assign prod_ext = {{(AW-PW){prod[PW-1]}}, prod};
      if (m == 0) begin : g_first
        assign acc_d[m][i] = prod_ext;
      end else begin : g_rest
        assign acc_d[m][i] = acc_q[m-1][i] + prod_ext;
      end
    end
  end

  // Arithmetic shift floors toward -inf before clamping to the output range.
  for (genvar i = 0; i < ROWS; i++) begin : g_sat
    logic signed [AW-1:0] sh;
    assign sh = acc_q[COLS-1][i] >>> FRAC_BIT;
    assign sat_vec[i*WIDTH +: WIDTH] = (sh > SAT_MAX) ? {1'b0, {(WIDTH-1){1'b1}}} :
                                       (sh < SAT_MIN) ? {1'b1, {(WIDTH-1){1'b0}}} :
                                       sh[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q         <= '0;
      out_valid_q <= 1'b0;
      out_vec_q   <= '0;
      for (int m = 0; m < COLS; m++) begin
        x_q[m] <= '0;
        for (int i = 0; i < ROWS; i++) begin
          acc_q[m][i] <= '0;
        end
      end
    end else if (clr) begin
      v_q         <= '0;
      out_valid_q <= 1'b0;
    end else if (!stall) begin
      v_q         <= {v_q[COLS-1:0], accept};
      out_valid_q <= v_q[COLS];
      out_vec_q   <= sat_vec;
      x_q[0]      <= in_vec;
      for (int m = 0; m < COLS; m++) begin
        if (m < COLS - 1) begin
          x_q[m+1] <= x_q[m];
        end
        for (int i = 0; i < ROWS; i++) begin
          acc_q[m][i] <= acc_d[m][i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_err_q <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          w_q[r][c] <= '0;
        end
      end
    end else if (w_we) begin
      if (busy) begin
        w_err_q <= 1'b1;
      end else if (row_ok) begin
        for (int c = 0; c < COLS; c++) begin
          w_q[w_row][c] <= $signed(w_data[c*WIDTH +: WIDTH]);
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_mv_array.sv
// Randomized scoreboard bench for systolic_mv_array against an integer reference model.
module tb_systolic_mv_array;

  localparam int W = 16;
  localparam int F = 10;
  localparam int R = 6;
  localparam int C = 6;
  localparam int LAT = C + 1;

  logic             clk;
  logic             rst_n;
  logic             clr;
  logic             w_we;
  logic [2:0]       w_row;
  logic [C*W-1:0]   w_data;
  logic             in_valid;
  logic             in_ready;
  logic [C*W-1:0]   in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [R*W-1:0]   out_vec;
  logic             busy;
  logic             w_err;

  systolic_mv_array #(.WIDTH(W), .FRAC_BIT(F), .ROWS(R), .COLS(C)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .w_we      (w_we),
    .w_row     (w_row),
    .w_data    (w_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .busy      (busy),
    .w_err     (w_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int mw [R][C];
  logic [R*W-1:0] sb [$];
  int xfer_cyc [$];
  logic [R*W-1:0] last_out = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer dot product, floor-divide by 2^F, clamp.
  function automatic logic [R*W-1:0] model(input logic [C*W-1:0] x);
    logic [R*W-1:0] y;
    longint s;
    for (int i = 0; i < R; i++) begin
      s = 0;
      for (int j = 0; j < C; j++) begin
        s += longint'(mw[i][j]) * longint'($signed(x[j*W +: W]));
      end
      s = s >>> F;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      y[i*W +: W] = s[15:0];
    end
    return y;
  endfunction

  function automatic int rs(input int m);
    return int'($urandom_range(2 * m - 1, 0)) - m;
  endfunction

  function automatic logic [C*W-1:0] rvec(input int m);
    logic [C*W-1:0] v;
    for (int j = 0; j < C; j++) v[j*W +: W] = 16'(rs(m));
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      xfer_cyc.push_back(cyc);
      last_out = out_vec;
      if (sb.size() == 0) begin
        check("unexpected_output", out_vec, 128'hx);
      end else begin
        check("result", out_vec, sb.pop_front());
      end
    end
  end

  task automatic wr(input int row, input logic [C*W-1:0] d, input bit apply);
    w_we = 1'b1;
    w_row = row[2:0];
    w_data = d;
    @(posedge clk); #1;
    w_we = 1'b0;
    if (apply) for (int j = 0; j < C; j++) mw[row][j] = int'($signed(d[j*W +: W]));
  endtask

  task automatic send(input logic [C*W-1:0] x);
    int n;
    in_valid = 1'b1;
    in_vec = x;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("send_timeout", 1'b0, 1'b1);
    end else begin
      sb.push_back(model(x));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while ((sb.size() != 0 || busy) && n < 200);
    check("drain_done", (sb.size() == 0 && !busy), 1'b1);
  endtask

  task automatic load_rand(input int m);
    for (int i = 0; i < R; i++) wr(i, rvec(m), 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [C*W-1:0] xv;
    logic [C*W-1:0] d;
    logic [R*W-1:0] held;
    int idv [C];
    int t0;
    int n;

    rst_n = 1'b1; clr = 1'b0; w_we = 1'b0; w_row = '0; w_data = '0;
    in_valid = 1'b0; in_vec = '0; out_ready = 1'b1;
    for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) mw[i][j] = 0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_vec", out_vec, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_w_err", w_err, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Identity weights and the reference vector.
    for (int i = 0; i < R; i++) begin
      d = '0;
      d[i*W +: W] = 16'd1024;
      wr(i, d, 1'b1);
    end
    idv = '{1024, 2048, -1024, 512, 0, 3072};
    for (int j = 0; j < C; j++) xv[j*W +: W] = 16'(idv[j]);
    send(xv);
    t0 = cyc;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("latency", 32'(cyc - t0), 32'(LAT));
    drain();
    check("identity_y", last_out, xv);

    // Back-to-back burst with random weights.
    load_rand(512);
    for (int k = 0; k < 10; k++) send(rvec(4096));
    drain();
    n = xfer_cyc.size();
    check("burst_count", (n >= 10), 1'b1);
    if (n >= 10) check("burst_gap", 32'(xfer_cyc[n-1] - xfer_cyc[n-10]), 32'd9);

    // Out-of-range row while idle is ignored without error.
    wr(7, rvec(30000), 1'b0);
    check("row7_w_err", w_err, 1'b0);
    send(rvec(4096));
    drain();

    // Truncation toward -inf.
    d = '0;
    d[W-1:0] = 16'd512;
    wr(0, d, 1'b1);
    for (int i = 1; i < R; i++) wr(i, '0, 1'b1);
    xv = '0; xv[W-1:0] = 16'd3;
    send(xv);
    drain();
    check("trunc_pos", last_out[W-1:0], 16'd1);
    xv[W-1:0] = 16'hFFFD;
    send(xv);
    drain();
    check("trunc_neg", last_out[W-1:0], 16'hFFFE);

    // Saturation both ways.
    for (int i = 0; i < R; i++) wr(i, {C{16'h7FFF}}, 1'b1);
    send({C{16'h7FFF}});
    drain();
    check("sat_pos", last_out, {R{16'h7FFF}});
    send({C{16'h8000}});
    drain();
    check("sat_neg", last_out, {R{16'h8000}});

    // Backpressure: results held stable, order preserved on release.
    load_rand(512);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(rvec(4096));
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("bp_valid", out_valid, 1'b1);
    held = out_vec;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_stable", out_vec, held);
      check("bp_in_ready", in_ready, 1'b0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();
    check("bp_sb_empty", 32'(sb.size()), 32'd0);

    // clr flushes in-flight vectors but keeps weights.
    for (int k = 0; k < 3; k++) send(rvec(4096));
    clr = 1'b1;
    @(negedge clk);
    check("clr_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    clr = 1'b0;
    sb.delete();
    repeat (12) @(posedge clk);
    #1;
    check("clr_busy", busy, 1'b0);
    send(rvec(4096));
    drain();

    // Weight write while busy is ignored and flagged.
    send(rvec(4096));
    wr(0, '0, 1'b0);
    check("busy_w_err", w_err, 1'b1);
    drain();
    check("w_err_sticky", w_err, 1'b1);
    send(rvec(4096));
    drain();

    // Asynchronous reset mid-stream.
    for (int k = 0; k < 8; k++) send(rvec(4096));
    check("pre_rst_valid", out_valid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_out_vec", out_vec, '0);
    check("arst_busy", busy, 1'b0);
    check("arst_w_err", w_err, 1'b0);
    check("arst_in_ready", in_ready, 1'b0);
    sb.delete();
    for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) mw[i][j] = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send({C{16'h7FFF}});
    drain();
    check("post_rst_zero_w", last_out, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
